// File: rtl/scdp_trace_checker_if.sv
// Trace preload write port for scdp_trace_checker.
// The master drives expected {pc, instr} entries into the checker's trace RAM.
interface scdp_trace_checker_if #(
    parameter int XLEN     = 32,
    parameter int TRACE_AW = 6
);
    logic                exp_wr_en;
    logic [TRACE_AW-1:0] exp_wr_addr;
    logic [XLEN-1:0]     exp_wr_pc;
    logic [XLEN-1:0]     exp_wr_instr;

    modport master (
        output exp_wr_en,
        output exp_wr_addr,
        output exp_wr_pc,
        output exp_wr_instr
    );

    modport slave (
        input exp_wr_en,
        input exp_wr_addr,
        input exp_wr_pc,
        input exp_wr_instr
    );
endinterface

// File: rtl/scdp_trace_checker.sv
// Commit-trace checker for the single-cycle datapath debug port.
// Compares fetched PC/instruction against a preloaded trace; detects halt and timeout.
module scdp_trace_checker #(
    parameter int XLEN        = 32,
    parameter int TRACE_AW    = 6,
    parameter int HALT_REPEAT = 3,
    parameter int MAX_CYCLES  = 1000
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [XLEN-1:0]     i_pc_in,
    input  logic [XLEN-1:0]     i_instr_in,
    scdp_trace_checker_if.slave wr,
    input  logic [TRACE_AW:0]   i_exp_len,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_pass,
    output logic                o_timeout,
    output logic                o_short_trace,
    output logic [7:0]          o_mismatch_count,
    output logic                o_first_fail_valid,
    output logic [TRACE_AW-1:0] o_first_fail_idx,
    output logic [15:0]         o_cycle_count
);
    localparam int DEPTH = 1 << TRACE_AW;
    localparam int HW    = $clog2(HALT_REPEAT) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          r_state;
    logic [XLEN-1:0]     r_mem_pc    [DEPTH];
    logic [XLEN-1:0]     r_mem_instr [DEPTH];
    logic [TRACE_AW:0]   r_len;
    logic [TRACE_AW:0]   r_idx;
    logic [HW-1:0]       r_halt;
    logic [XLEN-1:0]     r_prev_pc;
    logic                r_pass;
    logic                r_timeout;
    logic                r_short;
    logic [7:0]          r_mm;
    logic                r_ffv;
    logic [TRACE_AW-1:0] r_ffi;
    logic [15:0]         r_cc;

    logic                w_active;
    logic                w_hit;
    logic                w_miss;
    logic [7:0]          w_mm_next;
    logic [TRACE_AW:0]   w_idx_next;
    logic                w_same;
    logic                w_tmo;
    logic                w_halt;
    logic                w_short;

    // Trace RAM is deliberately not reset so a reset mid-run can replay it.
    always_ff @(posedge i_clk) begin
        if (wr.exp_wr_en && r_state != S_RUN) begin
            r_mem_pc[wr.exp_wr_addr]    <= wr.exp_wr_pc;
            r_mem_instr[wr.exp_wr_addr] <= wr.exp_wr_instr;
        end
    end

    always_comb begin
        w_active   = r_idx < r_len;
        w_hit      = (i_pc_in == r_mem_pc[r_idx[TRACE_AW-1:0]]) &&
                     (i_instr_in == r_mem_instr[r_idx[TRACE_AW-1:0]]);
        w_miss     = w_active && !w_hit;
        w_mm_next  = (w_miss && r_mm != 8'hFF) ? r_mm + 8'd1 : r_mm;
        w_idx_next = w_active ? r_idx + (TRACE_AW+1)'(1) : r_idx;
        w_same     = i_pc_in == r_prev_pc;
        w_tmo      = r_cc == 16'(MAX_CYCLES - 1);
        w_halt     = w_same && (r_halt == HW'(HALT_REPEAT - 1));
        // An entry compared on the halting edge counts as consumed.
        w_short    = w_idx_next < r_len;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_len     <= '0;
            r_idx     <= '0;
            r_halt    <= '0;
            r_prev_pc <= '0;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
            r_short   <= 1'b0;
            r_mm      <= '0;
            r_ffv     <= 1'b0;
            r_ffi     <= '0;
            r_cc      <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_len     <= i_exp_len;
                        r_idx     <= '0;
                        r_halt    <= '0;
                        r_prev_pc <= i_pc_in;
                        r_timeout <= 1'b0;
                        r_short   <= 1'b0;
                        r_mm      <= '0;
                        r_ffv     <= 1'b0;
                        r_ffi     <= '0;
                        r_cc      <= '0;
                        if (i_exp_len == '0) begin
                            r_state <= S_DONE;
                            r_pass  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_pass  <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    r_mm      <= w_mm_next;
                    r_idx     <= w_idx_next;
                    r_prev_pc <= i_pc_in;
                    r_halt    <= w_same ? r_halt + HW'(1) : '0;
                    if (w_miss && !r_ffv) begin
                        r_ffv <= 1'b1;
                        r_ffi <= r_idx[TRACE_AW-1:0];
                    end
                    if (w_tmo) begin
                        r_state   <= S_DONE;
                        r_timeout <= 1'b1;
                        r_pass    <= 1'b0;
                    end else begin
                        r_cc <= r_cc + 16'd1;
                        if (w_halt) begin
                            r_state <= S_DONE;
                            r_short <= w_short;
                            r_pass  <= !w_short && (w_mm_next == 8'd0);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy             = r_state == S_RUN;
    assign o_done             = r_state == S_DONE;
    assign o_pass             = r_pass;
    assign o_timeout          = r_timeout;
    assign o_short_trace      = r_short;
    assign o_mismatch_count   = r_mm;
    assign o_first_fail_valid = r_ffv;
    assign o_first_fail_idx   = r_ffi;
    assign o_cycle_count      = r_cc;
endmodule

// File: tb/tb_scdp_trace_checker.sv
// Directed bench for scdp_trace_checker.
// Instance A default, B deep trace for saturation, C short MAX_CYCLES.
module tb_scdp_trace_checker;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = '0;
    logic [31:0] instr = '0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic        start_c = 1'b0;
    logic [6:0]  len_a = '0;
    logic [9:0]  len_b = '0;

    logic        busy_a, done_a, pass_a, tmo_a, short_a, ffv_a;
    logic [7:0]  mm_a;
    logic [5:0]  ffi_a;
    logic [15:0] cc_a;
    logic        busy_b, done_b, pass_b, tmo_b, short_b, ffv_b;
    logic [7:0]  mm_b;
    logic [8:0]  ffi_b;
    logic [15:0] cc_b;
    logic        busy_c, done_c, pass_c, tmo_c, short_c, ffv_c;
    logic [7:0]  mm_c;
    logic [5:0]  ffi_c;
    logic [15:0] cc_c;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] seq_pc [4] = '{32'h0, 32'h4, 32'h8, 32'h8};
    logic [31:0] seq_in [4] = '{32'h00500093, 32'h00A00113, 32'h0000006F, 32'h0000006F};

    scdp_trace_checker_if #(.XLEN(32), .TRACE_AW(6)) ifa ();
    scdp_trace_checker_if #(.XLEN(32), .TRACE_AW(9)) ifb ();

    scdp_trace_checker #(.TRACE_AW(6), .MAX_CYCLES(1000)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start_a),
        .i_pc_in(pc), .i_instr_in(instr), .wr(ifa.slave), .i_exp_len(len_a),
        .o_busy(busy_a), .o_done(done_a), .o_pass(pass_a), .o_timeout(tmo_a),
        .o_short_trace(short_a), .o_mismatch_count(mm_a),
        .o_first_fail_valid(ffv_a), .o_first_fail_idx(ffi_a), .o_cycle_count(cc_a)
    );

    scdp_trace_checker #(.TRACE_AW(9), .MAX_CYCLES(1000)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start_b),
        .i_pc_in(pc), .i_instr_in(instr), .wr(ifb.slave), .i_exp_len(len_b),
        .o_busy(busy_b), .o_done(done_b), .o_pass(pass_b), .o_timeout(tmo_b),
        .o_short_trace(short_b), .o_mismatch_count(mm_b),
        .o_first_fail_valid(ffv_b), .o_first_fail_idx(ffi_b), .o_cycle_count(cc_b)
    );

    scdp_trace_checker #(.TRACE_AW(6), .MAX_CYCLES(20)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_start(start_c),
        .i_pc_in(pc), .i_instr_in(instr), .wr(ifa.slave), .i_exp_len(len_a),
        .o_busy(busy_c), .o_done(done_c), .o_pass(pass_c), .o_timeout(tmo_c),
        .o_short_trace(short_c), .o_mismatch_count(mm_c),
        .o_first_fail_valid(ffv_c), .o_first_fail_idx(ffi_c), .o_cycle_count(cc_c)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a();
        for (int k = 0; k < 4; k++) begin
            ifa.exp_wr_en    = 1'b1;
            ifa.exp_wr_addr  = 6'(k);
            ifa.exp_wr_pc    = seq_pc[k];
            ifa.exp_wr_instr = seq_in[k];
            tick();
        end
        ifa.exp_wr_en = 1'b0;
    endtask

    task automatic start_run_a(input logic [6:0] len);
        len_a   = len;
        pc      = 32'h0;
        instr   = 32'h0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic run_a(input logic [31:0] i1, output bit ok);
        start_run_a(7'd4);
        for (int k = 0; k < 4; k++) begin
            pc    = seq_pc[k];
            instr = (k == 1) ? i1 : seq_in[k];
            tick();
        end
        pc    = 32'h8;
        instr = 32'h0000006F;
        for (int j = 0; j < 20 && !done_a; j++) tick();
        ok = done_a;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_vec++;
        if ({busy_a, done_a, pass_a, tmo_a, short_a, ffv_a} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_flags got %b want 000000",
                     {busy_a, done_a, pass_a, tmo_a, short_a, ffv_a});
        end
        n_vec++;
        if ({mm_a, ffi_a, cc_a} !== 30'b0) begin
            n_err++;
            $display("FAIL reset_counts got %h want 0", {mm_a, ffi_a, cc_a});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_pass();
        bit ok;
        run_a(seq_in[1], ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL pass_done timed out got 0 want 1"); end
        n_vec++;
        if (pass_a !== 1'b1) begin n_err++; $display("FAIL pass_pass got %b want 1", pass_a); end
        n_vec++;
        if (mm_a !== 8'd0) begin n_err++; $display("FAIL pass_mm got %0d want 0", mm_a); end
        n_vec++;
        if (short_a !== 1'b0) begin n_err++; $display("FAIL pass_short got %b want 0", short_a); end
        n_vec++;
        if (busy_a !== 1'b0) begin n_err++; $display("FAIL pass_busy got %b want 0", busy_a); end
    endtask

    task automatic test_mismatch();
        bit ok;
        run_a(32'h00B00113, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL mm_done timed out got 0 want 1"); end
        n_vec++;
        if (pass_a !== 1'b0) begin n_err++; $display("FAIL mm_pass got %b want 0", pass_a); end
        n_vec++;
        if (mm_a !== 8'd1) begin n_err++; $display("FAIL mm_count got %0d want 1", mm_a); end
        n_vec++;
        if (ffv_a !== 1'b1) begin n_err++; $display("FAIL mm_ffv got %b want 1", ffv_a); end
        n_vec++;
        if (ffi_a !== 6'd1) begin n_err++; $display("FAIL mm_ffi got %0d want 1", ffi_a); end
    endtask

    task automatic test_zero_len();
        start_run_a(7'd0);
        n_vec++;
        if (done_a !== 1'b1 || pass_a !== 1'b1 || busy_a !== 1'b0) begin
            n_err++;
            $display("FAIL zero_len got done=%b pass=%b busy=%b want 1 1 0",
                     done_a, pass_a, busy_a);
        end
    endtask

    task automatic test_short();
        start_run_a(7'd6);
        instr = 32'h00500093;
        tick();
        tick();
        n_vec++;
        if (done_a !== 1'b0 || busy_a !== 1'b1) begin
            n_err++;
            $display("FAIL short_early got done=%b busy=%b want 0 1", done_a, busy_a);
        end
        tick();
        n_vec++;
        if (done_a !== 1'b1) begin n_err++; $display("FAIL short_done got %b want 1", done_a); end
        n_vec++;
        if (short_a !== 1'b1 || pass_a !== 1'b0) begin
            n_err++;
            $display("FAIL short_flags got short=%b pass=%b want 1 0", short_a, pass_a);
        end
        n_vec++;
        if (mm_a !== 8'd2 || ffi_a !== 6'd1) begin
            n_err++;
            $display("FAIL short_mm got mm=%0d ffi=%0d want 2 1", mm_a, ffi_a);
        end
    endtask

    task automatic test_timeout();
        len_a   = 7'd2;
        pc      = 32'hFFFC;
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            pc    = 32'(4 * (k - 1));
            instr = (k == 1) ? seq_in[0] : (k == 2) ? seq_in[1] : 32'h13;
            tick();
            if (k == 19) begin
                n_vec++;
                if (done_c !== 1'b0 || cc_c !== 16'd19) begin
                    n_err++;
                    $display("FAIL tmo_early got done=%b cc=%0d want 0 19", done_c, cc_c);
                end
            end
        end
        n_vec++;
        if (done_c !== 1'b1 || tmo_c !== 1'b1) begin
            n_err++;
            $display("FAIL tmo_flags got done=%b timeout=%b want 1 1", done_c, tmo_c);
        end
        n_vec++;
        if (cc_c !== 16'd19) begin n_err++; $display("FAIL tmo_cc got %0d want 19", cc_c); end
        n_vec++;
        if (pass_c !== 1'b0 || mm_c !== 8'd0 || short_c !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_stats got pass=%b mm=%0d short=%b want 0 0 0",
                     pass_c, mm_c, short_c);
        end
    endtask

    task automatic test_rst_mid_run();
        bit ok;
        start_run_a(7'd4);
        for (int k = 0; k < 4; k++) begin
            pc    = seq_pc[k];
            instr = (k == 1) ? 32'h00B00113 : seq_in[k];
            tick();
        end
        n_vec++;
        if (busy_a !== 1'b1 || mm_a !== 8'd1 || cc_a !== 16'd4) begin
            n_err++;
            $display("FAIL rst_pre got busy=%b mm=%0d cc=%0d want 1 1 4", busy_a, mm_a, cc_a);
        end
        pc  = 32'h8;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if ({busy_a, done_a, pass_a, ffv_a, mm_a, cc_a} !== 28'b0) begin
            n_err++;
            $display("FAIL rst_mid got %h want 0", {busy_a, done_a, pass_a, ffv_a, mm_a, cc_a});
        end
        run_a(seq_in[1], ok);
        n_vec++;
        if (!ok || pass_a !== 1'b1 || mm_a !== 8'd0) begin
            n_err++;
            $display("FAIL rst_replay got done=%b pass=%b mm=%0d want 1 1 0", ok, pass_a, mm_a);
        end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 300; k++) begin
            ifb.exp_wr_en    = 1'b1;
            ifb.exp_wr_addr  = 9'(k);
            ifb.exp_wr_pc    = 32'(4 * k);
            ifb.exp_wr_instr = 32'h0;
            tick();
        end
        ifb.exp_wr_en = 1'b0;
        len_b   = 10'd300;
        pc      = 32'hFFFF0000;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        instr   = 32'h1;
        for (int k = 1; k <= 300; k++) begin
            pc = 32'(4 * (k - 1));
            tick();
        end
        for (int j = 0; j < 10 && !done_b; j++) tick();
        n_vec++;
        if (done_b !== 1'b1) begin n_err++; $display("FAIL sat_done got %b want 1", done_b); end
        n_vec++;
        if (mm_b !== 8'd255) begin n_err++; $display("FAIL sat_mm got %0d want 255", mm_b); end
        n_vec++;
        if (ffv_b !== 1'b1 || ffi_b !== 9'd0 || pass_b !== 1'b0 || short_b !== 1'b0) begin
            n_err++;
            $display("FAIL sat_flags got ffv=%b ffi=%0d pass=%b short=%b want 1 0 0 0",
                     ffv_b, ffi_b, pass_b, short_b);
        end
    endtask

    initial begin
        ifa.exp_wr_en    = 1'b0;
        ifa.exp_wr_addr  = '0;
        ifa.exp_wr_pc    = '0;
        ifa.exp_wr_instr = '0;
        ifb.exp_wr_en    = 1'b0;
        ifb.exp_wr_addr  = '0;
        ifb.exp_wr_pc    = '0;
        ifb.exp_wr_instr = '0;
        test_reset();
        load_a();
        test_pass();
        test_mismatch();
        test_zero_len();
        test_short();
        test_timeout();
        test_rst_mid_run();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/scdp_trace_checker.md
# scdp_trace_checker

Synthesizable commit-trace checker that sits alongside the single-cycle datapath (SCDP) and consumes its debug outputs, `pc_out_debug` and `instruction_fetched`. It is the receiving end of the debug port that the SCDP bench drives and observes. An expected PC/instruction trace is preloaded through a write port. After `start`, the block compares each cycle's fetched PC and instruction against the next trace entry, detects program halt (PC self-loop) and timeout, and reports pass/fail plus mismatch statistics.

## Interface
- `XLEN`, 32: width of PC and instruction (equals `INSTRUCTION_SIZE`).
- `TRACE_AW`, 6: trace memory address width; depth = 2^TRACE_AW.
- `HALT_REPEAT`, 3: number of consecutive cycles with unchanged PC that declares halt.
- `MAX_CYCLES`, 1000: RUN cycle limit before timeout.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  single-cycle pulse; begins a check from IDLE or DONE.
- `pc_in`  in  XLEN  from SCDP `pc_out_debug`.
- `instr_in`  in  XLEN  from SCDP `instruction_fetched`.
- `exp_wr_en`  in  1  trace write strobe.
- `exp_wr_addr`  in  TRACE_AW  trace write index.
- `exp_wr_pc`  in  XLEN  expected PC for that entry.
- `exp_wr_instr`  in  XLEN  expected instruction for that entry.
- `exp_len`  in  TRACE_AW+1  number of valid trace entries (0..2^TRACE_AW); sampled at `start`.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `pass`  out  1  valid when `done` is high.
- `timeout`  out  1  the run ended on MAX_CYCLES.
- `short_trace`  out  1  halt occurred before all `exp_len` entries were consumed.
- `mismatch_count`  out  8  number of mismatched entries; saturates at 255.
- `first_fail_valid`  out  1  at least one mismatch seen.
- `first_fail_idx`  out  TRACE_AW  index of the first mismatch.
- `cycle_count`  out  16  RUN cycles elapsed.

## Operation
- States: IDLE, RUN, DONE.
- IDLE
  - `exp_wr_en` writes {pc, instr} into trace RAM at `exp_wr_addr`.
  - On `start`: latch `exp_len`, clear all statistics, set idx=0 and halt counter=0, load prev_pc with `pc_in`.
  - If latched length is 0, go directly to DONE with `pass`=1. Otherwise go to RUN.
- DONE: trace writes are accepted; `start` behaves as in IDLE.
- RUN, each cycle:
  - Compare {`pc_in`,`instr_in`} with trace[idx] using a combinational read. Both fields must match.
  - On mismatch: increment `mismatch_count` (saturating). If this is the first mismatch, set `first_fail_valid` and `first_fail_idx`=idx.
  - idx increments every cycle while idx<len. After that, compares stop but halt and timeout detection continue.
  - Halt counter: increments when `pc_in`==prev_pc, else clears. prev_pc<=`pc_in` every cycle.
  - `cycle_count` increments every cycle.
  - `exp_wr_en` is ignored in RUN.
- RUN exit conditions, evaluated on the same edge, highest priority first:
  1. `cycle_count`==MAX_CYCLES-1: go to DONE, `timeout`=1.
  2. Halt counter reaches HALT_REPEAT-1 while PC is still equal: go to DONE. Set `short_trace`=1 if idx<len at that point.
  3. No RUN exit on length alone. The program must halt, because a halting self-loop is how SCDP programs end; trace entries for the self-loop itself are part of the expected trace.
- `pass` = !`timeout` && !`short_trace` && `mismatch_count`==0, registered on entry to DONE.
- `start` while in RUN is ignored.
- `rst` (any state, including mid-RUN): state goes to IDLE and every output goes to 0 on the next edge. Trace RAM contents are retained; the RAM is not reset.

## Timing
- All outputs are registered; the reset value of every output is 0.
- `start` at edge N gives `busy`=1 after edge N; the first compare uses the inputs present at edge N+1.
- A mismatch sampled at edge K is visible in `mismatch_count`/`first_fail_*` after edge K.
- The halt decision uses HALT_REPEAT equal samples. `done` rises one cycle after the last equal sample and `busy` falls on the same edge.
- A trace write and `start` on the same edge: the write lands, and `exp_len` is sampled from the current input value.
- `cycle_count` is 16 bits; MAX_CYCLES must be ≤ 65535.

## Test plan
- Load 4 entries {0x0,0x00500093},{0x4,0x00A00113},{0x8,0x0000006F},{0x8,0x0000006F}, exp_len=4. Drive that PC/instr sequence, then hold PC=0x8 → `done`, `pass`=1, `mismatch_count`=0, `short_trace`=0.
- Same trace, but drive instr 0x00B00113 at idx1 → `pass`=0, `mismatch_count`=1, `first_fail_idx`=1.
- exp_len=6, drive PC=0x0 held constant from the first cycle → halt after 3 cycles, `short_trace`=1, `pass`=0.
- MAX_CYCLES=20, PC increments by 4 forever → `done` after 20 RUN cycles, `timeout`=1, `cycle_count`=19.
- Assert `rst` at RUN cycle 5 → all outputs 0, state IDLE. Then `start` with no reloads → the trace replays and passes.
- exp_len=0 with `start` → `done`=1, `pass`=1 one cycle later. Also: 300 mismatches → `mismatch_count`=255.
